pe_output_packer: RTL and testbench

- Downstream of the PE array; consumes the per-cycle write_data/write_valid produced by the PEs.
- Packs PACK_FACTOR consecutive PE output beats (NUM_PE operands each) into one wide word.
- Buffers packed words in an internal FIFO and drains them to the write-back/memory interface via valid/ready.
- Provides almost_full back-pressure to the PE controller so it can stall flush/write_valid generation.

---
 rtl/pe_output_packer_pkg.sv | 25 ++
 rtl/pe_out_fifo.sv | 57 +++++
 rtl/pe_output_packer.sv | 116 +++++++++++
 tb/tb_pe_output_packer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pe_output_packer_pkg.sv
// Shared defaults and helpers for the PE output packer slice.
// PRECISION_OP and PACK_FACTOR normally come from common.vh. The guards below
// let this slice build on its own while still deferring to the global value.
`ifndef PRECISION_OP
`define PRECISION_OP 16
`endif
`ifndef PACK_FACTOR
`define PACK_FACTOR 2
`endif

package pe_output_packer_pkg;

  localparam int DEF_NUM_PE          = 4;
  localparam int DEF_OP_WIDTH        = `PRECISION_OP;
  localparam int DEF_PACK_FACTOR     = `PACK_FACTOR;
  localparam int DEF_FIFO_ADDR_WIDTH = 3;
  localparam int DEF_AF_MARGIN       = 2;

  // Width of a slot counter for n slots. It is never zero, so n==1 still
  // gets a legal 1-bit vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// Generic first-word-fall-through FIFO. The head is visible on data_out while
// the FIFO is non-empty, and data_out reads as zero when it is empty.
module pe_out_fifo #(
  parameter int DATA_WIDTH = 129,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [FULL_CNT];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A pop on an empty FIFO is ignored. A push into a full FIFO is allowed
  // only when a real pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign data_out = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    end
  end

  // Storage has no reset. Stale entries are never visible because data_out
  // is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/pe_output_packer.sv
// Packs PACK_FACTOR consecutive PE beats into one wide word. Each word is
// buffered in an FWFT FIFO and drained over valid/ready, and the block raises
// almost_full as back-pressure toward the PE controller.
module pe_output_packer
  import pe_output_packer_pkg::*;
#(
  parameter int NUM_PE             = DEF_NUM_PE,
  parameter int OP_WIDTH           = DEF_OP_WIDTH,
  parameter int PACK_FACTOR        = DEF_PACK_FACTOR,
  parameter int FIFO_ADDR_WIDTH    = DEF_FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_MARGIN = DEF_AF_MARGIN
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear,
  input  logic                                   in_valid,
  input  logic                                   in_last,
  input  logic [NUM_PE*OP_WIDTH-1:0]             in_data,
  output logic                                   almost_full,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_PE*PACK_FACTOR*OP_WIDTH-1:0] out_data,
  output logic                                   out_last,
  output logic                                   overflow,
  output logic [15:0]                            word_count
);

  localparam int BEAT_W = NUM_PE * OP_WIDTH;
  localparam int WORD_W = BEAT_W * PACK_FACTOR;
  localparam int CNT_W  = cnt_width(PACK_FACTOR);
  localparam logic [CNT_W-1:0]         LAST_SLOT = CNT_W'(PACK_FACTOR - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] AF_THRESH =
    (FIFO_ADDR_WIDTH+1)'((1 << FIFO_ADDR_WIDTH) - ALMOST_FULL_MARGIN);

  logic [CNT_W-1:0]                   pack_cnt;
  logic [PACK_FACTOR-1:0][BEAT_W-1:0] pack_reg, word_asm;
  logic                               word_done, push_req, pop_req, accept;
  logic                               fifo_full, fifo_empty;
  logic [FIFO_ADDR_WIDTH:0]           fifo_count, occ_next;
  logic [WORD_W:0]                    fifo_dout;

  // Assemble the outgoing word from the held slots plus the live beat. Slot
  // 0 sits in the LSBs, and unfilled slots stay zero because pack_reg is
  // cleared after every push.
  always_comb begin
    word_asm = pack_reg;
    for (int j = 0; j < PACK_FACTOR; j++)
      if (CNT_W'(j) == pack_cnt) word_asm[j] = in_data;
  end

  assign word_done = in_valid && ((pack_cnt == LAST_SLOT) || in_last);
  assign push_req  = word_done && !clear;
  assign pop_req   = out_valid && out_ready && !clear;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign accept    = push_req && (!fifo_full || pop_req);
  assign occ_next  = fifo_count + (FIFO_ADDR_WIDTH+1)'(accept)
                                - (FIFO_ADDR_WIDTH+1)'(pop_req);

  pe_out_fifo #(
    .DATA_WIDTH (WORD_W + 1),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .clear    (clear),
    .push     (accept),
    .pop      (pop_req),
    .data_in  ({in_last, word_asm}),
    .data_out (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout[WORD_W-1:0];
  assign out_last  = fifo_dout[WORD_W];

  // Slot counter and partial-word holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_cnt <= '0;
      pack_reg <= '0;
    end else if (clear) begin
      pack_cnt <= '0;
      pack_reg <= '0;
    end else if (in_valid) begin
      if (word_done) begin
        pack_cnt <= '0;
        pack_reg <= '0;
      end else begin
        pack_reg[pack_cnt] <= in_data;
        pack_cnt           <= pack_cnt + 1'b1;
      end
    end
  end

  // Status flags and the accepted-word counter. The counter wraps naturally
  // at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      almost_full <= 1'b0;
      word_count  <= '0;
    end else if (clear) begin
      overflow    <= 1'b0;
      almost_full <= 1'b0;
      word_count  <= '0;
    end else begin
      if (push_req && !accept) overflow <= 1'b1;
      if (accept) word_count <= word_count + 16'd1;
      almost_full <= (occ_next >= AF_THRESH);
    end
  end

endmodule

// File: tb/tb_pe_output_packer.sv
// Bench for pe_output_packer. A queue-based reference model tracks the words
// that should be in flight, and directed scenarios are followed by random
// traffic.
module tb_pe_output_packer;

  localparam int NPE = 4, OPW = 16, PF = 2, AW = 3, MARGIN = 2;
  localparam int DEPTH = 1 << AW;
  localparam int BW = NPE * OPW;
  localparam int WW = BW * PF;

  logic          clk = 1'b0, reset = 1'b1, clear = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          almost_full, out_valid, out_last, overflow;
  logic [WW-1:0] out_data;
  logic [15:0]   word_count;

  int n_cmp = 0, n_err = 0;

  // Reference model state.
  logic [BW-1:0] m_beats[$];
  logic [WW:0]   m_q[$];
  bit            m_af, m_ovf;
  int            m_wc;

  always #5 clk = ~clk;

  pe_output_packer #(
    .NUM_PE(NPE), .OP_WIDTH(OPW), .PACK_FACTOR(PF),
    .FIFO_ADDR_WIDTH(AW), .ALMOST_FULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .almost_full(almost_full), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow),
    .word_count(word_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build a beat in which PE k carries base+k.
  function automatic logic [BW-1:0] mk(input int base);
    logic [BW-1:0] b;
    for (int k = 0; k < NPE; k++) b[k*OPW +: OPW] = OPW'(base + k);
    return b;
  endfunction

  task automatic model_reset();
    m_beats.delete(); m_q.delete();
    m_af = 0; m_ovf = 0; m_wc = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 256'(out_valid), 256'(m_q.size() > 0));
    chk({tag, ".data"},  256'(out_data),  (m_q.size() > 0) ? 256'(m_q[0][WW-1:0]) : 256'(0));
    chk({tag, ".last"},  256'(out_last),  (m_q.size() > 0) ? 256'(m_q[0][WW]) : 256'(0));
    chk({tag, ".af"},    256'(almost_full), 256'(m_af));
    chk({tag, ".ovf"},   256'(overflow),  256'(m_ovf));
    chk({tag, ".wc"},    256'(word_count), 256'(m_wc[15:0]));
  endtask

  // Apply one clock of behaviour using only the packing and FIFO rules.
  task automatic model_step(input bit iv, input bit il, input logic [BW-1:0] d,
                            input bit rdy, input bit clr);
    bit          pop;
    logic [WW:0] w;
    if (clr) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (iv) begin
      m_beats.push_back(d);
      if (m_beats.size() == PF || il) begin
        w = '0;
        foreach (m_beats[j]) w[j*BW +: BW] = m_beats[j];
        w[WW] = il;
        // After the pop, free space is exactly the accept rule.
        if (m_q.size() < DEPTH) begin
          m_q.push_back(w);
          m_wc = (m_wc + 1) % 65536;
        end else m_ovf = 1;
        m_beats.delete();
      end
    end
    m_af = (m_q.size() >= DEPTH - MARGIN);
  endtask

  task automatic cyc(input string tag, input bit iv, input bit il, input logic [BW-1:0] d,
                     input bit rdy, input bit clr);
    in_valid = iv; in_last = il; in_data = d; out_ready = rdy; clear = clr;
    @(negedge clk);
    check_model(tag);
    model_step(iv, il, d, rdy, clr);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; clear = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state, then two full beats packed into one word.
    cyc("t1a", 1, 0, mk(1), 1, 0);
    cyc("t1b", 1, 0, mk(5), 1, 0);
    chk("t1_valid", 256'(out_valid), 256'(1));
    chk("t1_data", 256'(out_data), 256'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
    chk("t1_last", 256'(out_last), 256'(0));
    chk("t1_wc", 256'(word_count), 256'(1));
    cyc("t1c", 0, 0, '0, 1, 0);

    // A single beat with in_last makes a half-empty word that closes a tile.
    cyc("t2a", 1, 1, {16'hD, 16'hC, 16'hB, 16'hA}, 1, 0);
    chk("t2_data", 256'(out_data), 256'(128'h000D_000C_000B_000A));
    chk("t2_last", 256'(out_last), 256'(1));
    cyc("t2b", 1, 0, mk(20), 1, 0);
    cyc("t2c", 1, 0, mk(24), 1, 0);
    chk("t2_fresh", 256'(out_data), 256'({mk(24), mk(20)}));
    cyc("t2d", 0, 0, '0, 1, 0);

    // Fill the FIFO with the consumer stalled, overflow it, then drain it.
    cyc("t3clr", 0, 0, '0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      cyc("t3fill", 1, 0, mk(100 + 8*i), 0, 0);
      cyc("t3fill", 1, 0, mk(104 + 8*i), 0, 0);
      if (i == 4) chk("t3_af5", 256'(almost_full), 256'(0));
      if (i == 5) chk("t3_af6", 256'(almost_full), 256'(1));
    end
    chk("t3_ovf", 256'(overflow), 256'(1));
    chk("t3_wc", 256'(word_count), 256'(8));
    for (int i = 0; i < 9; i++) cyc("t3drain", 0, 0, '0, 1, 0);
    chk("t3_empty", 256'(out_valid), 256'(0));

    // With the FIFO full, a pop and a completing beat in the same cycle.
    cyc("t4clr", 0, 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc("t4fill", 1, 0, mk(300 + 8*i), 0, 0);
      cyc("t4fill", 1, 0, mk(304 + 8*i), 0, 0);
    end
    cyc("t4a", 1, 0, mk(400), 0, 0);
    cyc("t4b", 1, 0, mk(404), 1, 0);
    chk("t4_ovf", 256'(overflow), 256'(0));
    chk("t4_wc", 256'(word_count), 256'(9));
    chk("t4_af", 256'(almost_full), 256'(1));
    cyc("t4full", 1, 1, mk(500), 0, 0);
    chk("t4_still_full", 256'(overflow), 256'(1));

    // Asynchronous reset in the middle of a partially packed word.
    cyc("t5a", 1, 0, mk(600), 0, 0);
    #2 reset = 1;
    #1;
    chk("t5_valid", 256'(out_valid), 256'(0));
    chk("t5_af", 256'(almost_full), 256'(0));
    chk("t5_ovf", 256'(overflow), 256'(0));
    chk("t5_wc", 256'(word_count), 256'(0));
    model_reset();
    @(negedge clk); #1 reset = 0;
    @(posedge clk); #1;
    cyc("t5b", 1, 0, mk(700), 1, 0);
    cyc("t5c", 1, 0, mk(704), 1, 0);
    chk("t5_data", 256'(out_data), 256'({mk(704), mk(700)}));
    cyc("t5d", 0, 0, '0, 1, 0);

    // clear takes priority over a completing beat.
    cyc("t6a", 1, 0, mk(800), 0, 0);
    cyc("t6b", 1, 0, mk(804), 0, 1);
    chk("t6_valid", 256'(out_valid), 256'(0));
    chk("t6_wc", 256'(word_count), 256'(0));
    chk("t6_ovf", 256'(overflow), 256'(0));

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc("rnd", ($urandom_range(99) < 60), ($urandom_range(99) < 15),
          BW'({$urandom, $urandom}), ($urandom_range(99) < 45),
          ($urandom_range(199) == 0));
    end
    cyc("final", 0, 0, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
